// File: rtl/bcd_counter_n_if.sv
// Purpose : bundles the control/data signals of bcd_counter_n into one port.
// Latency : none, this is wiring only.
// Backpressure: none; the counter accepts a command every cycle.
// Ports   : en/up/load/load_val flow master -> slave,
//           bcd/tc/load_err flow slave -> master.
interface bcd_counter_n_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd;
  logic                  tc;
  logic                  load_err;

  modport master (
    output en, up, load, load_val,
    input  bcd, tc, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output bcd, tc, load_err
  );
endinterface

// File: rtl/bcd_counter_n.sv
// Purpose : N-digit synchronous BCD up/down counter with load, wrap/saturate and tc pulse.
// Latency : one cycle; inputs sampled at a rising edge are reflected right after it.
// Backpressure: none; one command (rst > load > en) is consumed every cycle.
// Ports   : clk, rst (sync, active-high); bus.slave carries en, up, load,
//           load_val (in) and bcd, tc, load_err (out, all registered).
//           DIGITS (1..8) digits, WRAP=1 wraps at MIN/MAX, WRAP=0 saturates.
module bcd_counter_n #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  bcd_counter_n_if.slave   bus
);

  logic [4*DIGITS-1:0] bcd_q;
  logic                tc_q;
  logic                err_q;

  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] clamp_val;
  logic                clamp_err;
  logic                boundary;
  logic                carry;
  logic [3:0]          d;

  // Clamp the load value digit by digit, and build the ripple step.
  // carry starts at 1 (digit 0 always steps) and survives a digit only
  // when that digit rolls over, so after the last digit it is high exactly
  // when the whole count was at MAX (up) or MIN (down).
  always_comb begin
    step_val  = '0;
    clamp_val = '0;
    clamp_err = 1'b0;
    carry     = 1'b1;
    d         = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      d = bus.load_val[4*k +: 4];
      if (d > 4'd9) begin
        clamp_val[4*k +: 4] = 4'd9;
        clamp_err           = 1'b1;
      end else begin
        clamp_val[4*k +: 4] = d;
      end

      d = bcd_q[4*k +: 4];
      step_val[4*k +: 4] = d;
      if (carry) begin
        if (bus.up) begin
          if (d == 4'd9) begin
            step_val[4*k +: 4] = 4'd0;
          end else begin
            step_val[4*k +: 4] = d + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            step_val[4*k +: 4] = 4'd9;
          end else begin
            step_val[4*k +: 4] = d - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
    boundary = carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      tc_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (bus.load) begin
      bcd_q <= clamp_val;
      tc_q  <= 1'b0;
      err_q <= clamp_err;
    end else if (bus.en) begin
      // In saturate mode a step against the boundary leaves the value alone
      // but still reports tc every such cycle.
      if (!(boundary && (WRAP == 0))) begin
        bcd_q <= step_val;
      end
      tc_q  <= boundary;
      err_q <= 1'b0;
    end else begin
      tc_q  <= 1'b0;
      err_q <= 1'b0;
    end
  end

  assign bus.bcd      = bcd_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = err_q;

endmodule
